// File: rtl/run_ctrl.sv
`default_nettype none
// run_ctrl: holds the core in reset, runs it until halt PC or cycle limit, then reports done.
// Rev 1.0 - initial release
module run_ctrl #(
  parameter int D       = 12,
  parameter int HALT_PC = 128,
  parameter int CLR_CYC = 2,
  parameter int CW      = 16,
  parameter int TIMEOUT = 2**CW-1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [D-1:0]  prog_ctr,
  output logic          core_reset,
  output logic          core_en,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycle_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CLR  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [D-1:0]  c_HALT     = D'(HALT_PC);
  localparam logic [CW-1:0] c_TMO      = CW'(TIMEOUT);
  localparam logic [CW-1:0] c_CNT_MAX  = '1;
  localparam logic [3:0]    c_CLR_LOAD = 4'(CLR_CYC - 1);

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [3:0]    r_clr;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic          r_tmo;
  logic          w_halt;
  logic          w_tmo;

  assign w_halt    = (prog_ctr == c_HALT);
  assign w_tmo     = (r_cnt == c_TMO);
  assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Abort beats halt, halt beats timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req) w_next = S_CLR;
      S_CLR: begin
        if (!req)              w_next = S_IDLE;
        else if (r_clr == 4'd0) w_next = S_RUN;
      end
      S_RUN: begin
        if (!req)              w_next = S_IDLE;
        else if (w_halt || w_tmo) w_next = S_DONE;
      end
      S_DONE: if (!req) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    core_reset = 1'b1;
    core_en    = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_RUN: begin
        core_reset = 1'b0;
        core_en    = 1'b1;
      end
      S_DONE: begin
        core_reset = 1'b0;
        done       = 1'b1;
      end
      default: ;
    endcase
  end

  // cycle_cnt names the RUN cycle in progress, so it is 1 in the first RUN cycle
  // and the halting edge leaves it equal to the number of RUN cycles spent.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr <= 4'd0;
      r_cnt <= '0;
      r_tmo <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_clr <= c_CLR_LOAD;
            r_cnt <= '0;
            r_tmo <= 1'b0;
          end
        end
        S_CLR: begin
          if (!req) begin
            r_tmo <= 1'b0;
          end else if (r_clr != 4'd0) begin
            r_clr <= r_clr - 4'd1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_RUN: begin
          if (!req || w_halt) begin
            r_tmo <= 1'b0;
          end else if (w_tmo) begin
            r_tmo <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign timeout   = r_tmo;
  assign cycle_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_run_ctrl.sv
`default_nettype none
// tb_run_ctrl: directed runs of run_ctrl; expectations are queued and checked by monitors.
// Rev 1.0 - initial release
module tb_run_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [11:0] prog_ctr = 12'd0;
  logic        core_reset;
  logic        core_en;
  logic        done;
  logic        timeout;
  logic [15:0] cycle_cnt;

  run_ctrl #(
    .D(12), .HALT_PC(128), .CLR_CYC(2), .CW(16), .TIMEOUT(20)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .prog_ctr(prog_ctr),
    .core_reset(core_reset),
    .core_en(core_en),
    .done(done),
    .timeout(timeout),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        cr;
    logic        ce;
    logic        dn;
    logic        to;
    logic [15:0] cc;
  } exp_t;

  typedef struct {
    int   cyc;
    int   cc;
    logic to;
  } dn_t;

  exp_t exp_q[$];
  dn_t  dn_q[$];
  exp_t m_e;
  dn_t  m_d;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   en_cnt = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      n_vec++;
      if ({core_reset, core_en, done, timeout, cycle_cnt} !== {m_e.cr, m_e.ce, m_e.dn, m_e.to, m_e.cc}) begin
        n_err++;
        $display("FAIL %s @cyc %0d: got rst=%b en=%b done=%b to=%b cnt=%0d, want rst=%b en=%b done=%b to=%b cnt=%0d",
                 m_e.name, cyc, core_reset, core_en, done, timeout, cycle_cnt,
                 m_e.cr, m_e.ce, m_e.dn, m_e.to, m_e.cc);
      end
    end
    if (done === 1'b1 && prev_done !== 1'b1) begin
      n_vec++;
      if (dn_q.size() == 0) begin
        n_err++;
        $display("FAIL done_rise @cyc %0d: got unexpected done, want none", cyc);
      end else begin
        m_d = dn_q.pop_front();
        if (cyc != m_d.cyc || cycle_cnt !== 16'(m_d.cc) || timeout !== m_d.to || en_cnt != m_d.cc) begin
          n_err++;
          $display("FAIL done_rise: got cyc=%0d cnt=%0d to=%b en_cycles=%0d, want cyc=%0d cnt=%0d to=%b en_cycles=%0d",
                   cyc, cycle_cnt, timeout, en_cnt, m_d.cyc, m_d.cc, m_d.to, m_d.cc);
        end
      end
    end
    if (core_reset === 1'b1) en_cnt = 0;
    else if (core_en === 1'b1) en_cnt++;
    prev_done = done;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_o(input string nm, input logic cr, input logic ce,
                          input logic dn, input logic to, input int cc);
    exp_t e;
    e.name = nm;
    e.cr   = cr;
    e.ce   = ce;
    e.dn   = dn;
    e.to   = to;
    e.cc   = 16'(cc);
    exp_q.push_back(e);
  endtask

  // Called just before req rises: done must rise CLR_CYC+N cycles after the sampling edge.
  task automatic sched_done(input int n, input logic to);
    dn_t d;
    d.cyc = cyc + 1 + 2 + n;
    d.cc  = n;
    d.to  = to;
    dn_q.push_back(d);
  endtask

  initial begin
    reset = 1'b1;
    step(3);
    expect_o("reset", 1, 0, 0, 0, 0);
    reset = 1'b0;
    step(2);
    expect_o("idle_after_reset", 1, 0, 0, 0, 0);

    prog_ctr = 12'd128;
    step(2);
    expect_o("halt_in_idle", 1, 0, 0, 0, 0);

    // nominal run, halt on RUN cycle 10
    prog_ctr = 12'd0;
    req = 1'b1;
    sched_done(10, 1'b0);
    step(1);
    expect_o("clr1", 1, 0, 0, 0, 0);
    step(1);
    expect_o("clr2", 1, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      step(1);
      expect_o("run", 0, 1, 0, 0, i);
      if (i == 10) prog_ctr = 12'd128;
    end
    step(1);
    expect_o("nominal_done", 0, 0, 1, 0, 10);
    prog_ctr = 12'd0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      expect_o("hold", 0, 0, 1, 0, 10);
    end
    req = 1'b0;
    step(1);
    expect_o("release_idle", 1, 0, 0, 0, 10);

    // timeout after 20 RUN cycles
    req = 1'b1;
    sched_done(20, 1'b1);
    step(22);
    expect_o("run20", 0, 1, 0, 0, 20);
    step(1);
    expect_o("timeout_done", 0, 0, 1, 1, 20);
    req = 1'b0;
    step(1);

    // halt and timeout on the same edge
    req = 1'b1;
    sched_done(20, 1'b0);
    step(22);
    prog_ctr = 12'd128;
    step(1);
    expect_o("simul_done", 0, 0, 1, 0, 20);
    req = 1'b0;
    prog_ctr = 12'd0;
    step(1);

    // halt PC present during CLR is ignored; halts after RUN cycle 1
    prog_ctr = 12'd128;
    req = 1'b1;
    sched_done(1, 1'b0);
    step(2);
    expect_o("clr_cleared", 1, 0, 0, 0, 0);
    step(1);
    expect_o("run1", 0, 1, 0, 0, 1);
    step(1);
    expect_o("halt_n1_done", 0, 0, 1, 0, 1);
    req = 1'b0;
    prog_ctr = 12'd0;
    step(1);

    // abort in RUN at cycle_cnt=5, then abort in CLR
    req = 1'b1;
    step(7);
    expect_o("run5", 0, 1, 0, 0, 5);
    req = 1'b0;
    step(1);
    expect_o("abort_run", 1, 0, 0, 0, 5);
    step(1);
    expect_o("abort_hold", 1, 0, 0, 0, 5);
    req = 1'b1;
    step(1);
    expect_o("reclr", 1, 0, 0, 0, 0);
    req = 1'b0;
    step(1);
    expect_o("abort_clr", 1, 0, 0, 0, 0);
    step(1);

    // reset mid-run at cycle_cnt=7
    req = 1'b1;
    step(9);
    expect_o("run7", 0, 1, 0, 0, 7);
    reset = 1'b1;
    step(1);
    expect_o("reset_mid", 1, 0, 0, 0, 0);
    step(1);
    expect_o("reset_req_held", 1, 0, 0, 0, 0);
    reset = 1'b0;
    step(3);
    expect_o("restart_run1", 0, 1, 0, 0, 1);
    req = 1'b0;
    step(1);
    expect_o("final_idle", 1, 0, 0, 0, 1);

    step(2);
    n_vec++;
    if (dn_q.size() != 0) begin
      n_err++;
      $display("FAIL done_pending: got %0d runs without done, want 0", dn_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter D, default 12: program counter width.
REQ-002 Parameter HALT_PC, default 128: program counter value that marks program completion.
REQ-003 Parameter CLR_CYC, default 2: number of cycles the core is held in reset before a run, range 1..15.
REQ-004 Parameter CW, default 16: cycle counter width.
REQ-005 Parameter TIMEOUT, default 2**CW-1: RUN cycle limit before a forced stop.
REQ-006 The block SHALL have a single clock `clk`, and `reset` SHALL be synchronous and active-high.
REQ-007 Port list, clock and reset first:
- `clk`  in  1: the only clock.
- `reset`  in  1: synchronous, active-high.
- `req`  in  1: level run request from the host.
- `prog_ctr`  in  D: core program counter.
- `core_reset`  out  1: reset to the core's PC and flags.
- `core_en`  out  1: core clock enable (PC advance, reg/mem writes).
- `done`  out  1: run finished.
- `timeout`  out  1: the finished run ended by cycle limit, not by halt.
- `cycle_cnt`  out  CW: number of RUN cycles in the current or last run.

Function
REQ-008 The FSM SHALL have the states IDLE, CLR, RUN and DONE, held in a registered state variable.
REQ-009 All outputs SHALL be registered or decoded from registered state only, with no combinational path from `req` or `prog_ctr` to any output.
REQ-010 Output decode per state:
- IDLE: core_reset=1, core_en=0, done=0.
- CLR: core_reset=1, core_en=0, done=0.
- RUN: core_reset=0, core_en=1, done=0.
- DONE: core_reset=0, core_en=0, done=1.
REQ-011 IDLE SHALL move to CLR on the clock edge where req=1; otherwise it stays in IDLE.
REQ-012 On entry to CLR, `cycle_cnt` SHALL clear to 0, `timeout` SHALL clear to 0, and an internal clear counter SHALL load CLR_CYC-1.
REQ-013 CLR SHALL last exactly CLR_CYC cycles, then move to RUN.
REQ-014 Each cycle in RUN SHALL increment `cycle_cnt` by 1; `cycle_cnt` saturates at 2**CW-1 and never wraps.
REQ-015 In RUN, prog_ctr==HALT_PC sampled at a clock edge SHALL move the FSM to DONE with timeout=0; `cycle_cnt` does not increment on that edge.
REQ-016 In RUN, cycle_cnt==TIMEOUT at a clock edge SHALL move the FSM to DONE with timeout=1.
REQ-017 If halt and timeout occur on the same edge, halt SHALL win: DONE with timeout=0.
REQ-018 If req=0 in RUN or CLR (abort), the FSM SHALL move to IDLE on that edge; done stays 0, `cycle_cnt` holds its value, and timeout=0.
- Priority on a RUN edge: abort, then halt, then timeout.
REQ-019 DONE SHALL hold `done`, `timeout` and `cycle_cnt` stable until req=0, then move to IDLE; a new run requires req to go low then high again.
REQ-020 `done` SHALL rise exactly one cycle after the halt/timeout edge and stay high for at least one cycle.
REQ-021 Latency, with req rising before edge k and HALT_PC reached at the N-th RUN cycle:
- CLR occupies cycles k+1..k+CLR_CYC.
- RUN starts at cycle k+CLR_CYC+1.
- done=1 from cycle k+CLR_CYC+N+1.
- cycle_cnt=N.
REQ-022 prog_ctr==HALT_PC while in IDLE, CLR or DONE SHALL be ignored.

Reset
REQ-023 While reset=1, on each clock edge the block SHALL set: state=IDLE, core_reset=1, core_en=0, done=0, timeout=0, cycle_cnt=0, clear counter=0.
REQ-024 Reset SHALL take priority over `req` and every other input, including in mid-run RUN or DONE.
REQ-025 Reset deassertion SHALL leave the FSM in IDLE; it does not start a run, even if req=1. Entry to CLR needs an edge with reset=0 and req=1.

Verification
REQ-026 Nominal run: reset, then req=1 and prog_ctr reaching 128 on the 10th RUN cycle -> core_reset high for exactly 2 cycles, core_en high for 10 cycles, then done=1, timeout=0, cycle_cnt=10.
REQ-027 Timeout: TIMEOUT=20, prog_ctr never 128 -> DONE after 20 RUN cycles, timeout=1, cycle_cnt=20, core_en=0.
REQ-028 Simultaneous: TIMEOUT=20 and prog_ctr=128 on the edge where cycle_cnt=20 -> done=1, timeout=0.
REQ-029 Abort: req dropped in RUN at cycle_cnt=5 -> next cycle IDLE, core_reset=1, done=0, cycle_cnt=5; req=1 again -> cycle_cnt=0 on CLR entry.
REQ-030 Handshake hold: req kept high after done -> done, cycle_cnt and timeout stay stable for 50 cycles, no new run starts; req=0 -> IDLE next cycle.
REQ-031 Reset mid-run: reset=1 at cycle_cnt=7 with req=1 -> next cycle all outputs at reset values; after reset=0 with req=1, CLR entry occurs on the next edge.
